// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one combinational ALU between
// two valid/ready requesters, returning one tagged, back-pressured response.
module alu_req_arbiter #(
  parameter int WIDTH       = 32,
  parameter int SEL_W       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [SEL_W-1:0] req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_inp_1,
  output logic [WIDTH-1:0] alu_inp_2,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic [3:0]       cnt;
  logic             any_req;
  logic             win;
  logic [SEL_W-1:0] win_sel;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             win_legal;
  logic             ovf_op;
  logic             hs;

  always_comb begin
    any_req = req0_valid | req1_valid;
    win     = 1'b0;
    unique case (1'b1)
      req0_valid & req1_valid:  win = ~last_grant;
      req1_valid & ~req0_valid: win = 1'b1;
      default:                  win = 1'b0;
    endcase
    win_sel = win ? req1_sel : req0_sel;
    win_a   = win ? req1_a : req0_a;
    win_b   = win ? req1_b : req0_b;
    win_legal = (win_sel < SEL_W'(8))
             || (win_sel == SEL_W'(9))
             || (win_sel == SEL_W'(10));
    // ALU overflow is only meaningful for add and increment
    ovf_op = (alu_sel == SEL_W'(5))
          || (alu_sel == SEL_W'(7));
    hs = (state == IDLE) & any_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (hs) state_nx = win_legal ? EXEC : RESP;
      EXEC: if (cnt == 4'd0) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    rsp_valid  = (state == RESP);
    req0_ready = hs & ~win;
    req1_ready = hs & win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= 1'b1;
      cnt          <= 4'd0;
      alu_sel      <= '0;
      alu_inp_1    <= '0;
      alu_inp_2    <= '0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            last_grant <= win;
            rsp_id     <= win;
            if (win_legal) begin
              alu_sel   <= win_sel;
              alu_inp_1 <= win_a;
              alu_inp_2 <= win_b;
              cnt       <= CNT_LOAD;
            end else begin
              rsp_err      <= 1'b1;
              rsp_result   <= '0;
              rsp_overflow <= 1'b0;
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_result   <= alu_result;
            rsp_overflow <= ovf_op & alu_overflow;
            rsp_err      <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
